// File: rtl/cdc_hsk_src_arb.sv
// cdc_hsk_src_arb: per-channel FIFOs with round-robin arbitration feeding a 4-phase handshake synchronizer
module cdc_hsk_src_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_ID_W    = $clog2(NUM_CH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data_i,
  input  logic [NUM_CH-1:0]             ch_valid_i,
  output logic [NUM_CH-1:0]             ch_ready_o,
  output logic [CH_ID_W+DATA_WIDTH-1:0] hsk_data_o,
  output logic                          hsk_valid_o,
  input  logic                          hsk_ack_i,
  output logic                          busy_o,
  output logic [31:0]                   xfer_cnt_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_e;
  state_e state_q, state_d;
  logic [NUM_CH-1:0] push, pop, nonempty;
  logic [NUM_CH*DATA_WIDTH-1:0] head;
  logic [CH_ID_W-1:0] ptr_q, gnt_ch;
  logic gnt_found, load, done, valid_q;
  logic [CH_ID_W+DATA_WIDTH-1:0] data_q;
  logic [31:0] xfer_cnt_q;
  assign push = ch_valid_i & ch_ready_o;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0] cnt_q;
    // storage needs no reset: the pointers alone decide which entries are live
    always_ff @(posedge clk_i)
      if (push[k]) mem_q[wr_q] <= ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    // pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_q + PW'(push[k]);
        rd_q  <= rd_q + PW'(pop[k]);
        cnt_q <= cnt_q + (PW+1)'(push[k]) - (PW+1)'(pop[k]);
      end
    end
    assign nonempty[k] = cnt_q != '0;
    assign ch_ready_o[k] = cnt_q != (PW+1)'(FIFO_DEPTH);
    assign head[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_q];
  end
  // first non-empty channel at or after the pointer; the descending scan lets the nearest one win
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (nonempty[(int'(ptr_q) + i) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_ch = CH_ID_W'((int'(ptr_q) + i) % NUM_CH);
      end
    end
  end
  // handshake sequencing; a grant is only issued once any stale ack has dropped
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    done = 1'b0;
    pop = '0;
    case (state_q)
      IDLE: if (!hsk_ack_i && gnt_found) begin
        state_d = SEND;
        load = 1'b1;
      end
      SEND: if (hsk_ack_i) state_d = WAIT_LOW;
      WAIT_LOW: if (!hsk_ack_i) begin
        state_d = IDLE;
        done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) pop[gnt_ch] = 1'b1;
  end
  // registered handshake outputs; data holds from grant until the next grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ptr_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= state_d == SEND;
      xfer_cnt_q <= xfer_cnt_q + 32'(done);
      if (load) begin
        data_q <= {gnt_ch, head[gnt_ch*DATA_WIDTH +: DATA_WIDTH]};
        ptr_q  <= gnt_ch == CH_ID_W'(NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
      end
    end
  end
  assign hsk_valid_o = valid_q;
  assign hsk_data_o  = data_q;
  assign busy_o      = state_q != IDLE;
  assign xfer_cnt_o  = xfer_cnt_q;
endmodule

// File: tb/tb_cdc_hsk_src_arb.sv
// tb_cdc_hsk_src_arb: directed scenarios plus randomized traffic against a queue-based model
module tb_cdc_hsk_src_arb;
  localparam int DW = 16;
  localparam int NCH = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NCH*DW-1:0] ch_data_i = '0;
  logic [NCH-1:0] ch_valid_i = '0;
  logic [NCH-1:0] ch_ready_o;
  logic [DW+1:0] hsk_data_o;
  logic hsk_valid_o;
  logic hsk_ack_i = 1'b0;
  logic busy_o;
  logic [31:0] xfer_cnt_o;
  int checks = 0;
  int errors = 0;
  logic [NCH-1:0] acc;
  logic [NCH*DW-1:0] acc_data;
  logic [DW-1:0] q[NCH][$];

  cdc_hsk_src_arb #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i),
    .ch_ready_o(ch_ready_o), .hsk_data_o(hsk_data_o), .hsk_valid_o(hsk_valid_o),
    .hsk_ack_i(hsk_ack_i), .busy_o(busy_o), .xfer_cnt_o(xfer_cnt_o));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    acc = ch_valid_i & ch_ready_o;
    acc_data = ch_data_i;
    @(posedge clk);
    #1;
    ch_valid_i = ch_valid_i & ~acc;
  endtask

  task automatic do_reset(input logic ack);
    ch_valid_i = '0;
    hsk_ack_i = ack;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(output logic [DW+1:0] d, output bit ok);
    int n;
    ok = 1'b0;
    d = '0;
    n = 0;
    while (!hsk_valid_o && n < 40) begin tick(); n++; end
    if (!hsk_valid_o) return;
    d = hsk_data_o;
    repeat ($urandom_range(0, 2)) tick();
    hsk_ack_i = 1'b1;
    n = 0;
    while (hsk_valid_o && n < 40) begin tick(); n++; end
    if (hsk_valid_o) return;
    repeat ($urandom_range(0, 2)) tick();
    hsk_ack_i = 1'b0;
    tick();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", hsk_valid_o); end
    checks++; if (hsk_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", hsk_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if (xfer_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", xfer_cnt_o); end
    checks++; if (ch_ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b exp 1111", ch_ready_o); end
  endtask

  task automatic test_single();
    ch_data_i[2*DW +: DW] = 16'hBEEF;
    ch_valid_i = 4'b0100;
    tick();
    checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", hsk_valid_o); end
    tick();
    checks++; if (hsk_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", hsk_valid_o); end
    checks++; if (hsk_data_o !== 18'h2BEEF) begin errors++; $display("FAIL single_data: got %h exp 2beef", hsk_data_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy_o); end
    repeat (2) tick();
    hsk_ack_i = 1'b1;
    tick();
    checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL single_vdrop: got %b exp 0", hsk_valid_o); end
    repeat (2) tick();
    hsk_ack_i = 1'b0;
    tick();
    checks++; if (xfer_cnt_o !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d exp 1", xfer_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_round_robin();
    logic [DW+1:0] d, exp_d;
    bit ok;
    do_reset(1'b0);
    for (int k = 0; k < NCH; k++) ch_data_i[k*DW +: DW] = 16'(32'h1000 + k);
    ch_valid_i = 4'hF;
    tick();
    for (int i = 0; i < NCH; i++) begin
      run_xfer(d, ok);
      exp_d = {2'(i), 16'(32'h1000 + i)};
      checks++; if (!ok || d !== exp_d) begin errors++; $display("FAIL rr_order: got %h ok=%0d exp %h", d, ok, exp_d); end
    end
    ch_data_i[0 +: DW] = 16'h2000;
    ch_data_i[3*DW +: DW] = 16'h2003;
    ch_valid_i = 4'b1001;
    tick();
    run_xfer(d, ok);
    checks++; if (!ok || d !== 18'h02000) begin errors++; $display("FAIL rr_pair_first: got %h ok=%0d exp 02000", d, ok); end
    run_xfer(d, ok);
    checks++; if (!ok || d !== 18'h32003) begin errors++; $display("FAIL rr_pair_second: got %h ok=%0d exp 32003", d, ok); end
    checks++; if (xfer_cnt_o !== 32'd6) begin errors++; $display("FAIL rr_cnt: got %0d exp 6", xfer_cnt_o); end
  endtask

  task automatic test_full();
    logic [DW-1:0] w[6];
    logic [DW+1:0] d, exp_d;
    bit ok;
    int nxt, nacc;
    for (int i = 0; i < 6; i++) w[i] = 16'(32'hA000 + i);
    nxt = 0;
    nacc = 0;
    hsk_ack_i = 1'b0;
    repeat (16) begin
      if (!ch_valid_i[1] && nxt < 6) begin ch_data_i[DW +: DW] = w[nxt]; ch_valid_i[1] = 1'b1; nxt++; end
      if (hsk_valid_o) hsk_ack_i = 1'b1;
      tick();
      if (acc[1]) nacc++;
    end
    checks++; if (nacc != 5) begin errors++; $display("FAIL full_accepted: got %0d exp 5", nacc); end
    checks++; if (ch_ready_o[1] !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", ch_ready_o[1]); end
    checks++; if (hsk_data_o !== {2'd1, w[0]}) begin errors++; $display("FAIL full_head: got %h exp %h", hsk_data_o, {2'd1, w[0]}); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_stall: got %b exp 1", busy_o); end
    hsk_ack_i = 1'b0;
    for (int i = 1; i < 6; i++) begin
      run_xfer(d, ok);
      exp_d = {2'd1, w[i]};
      checks++; if (!ok || d !== exp_d) begin errors++; $display("FAIL full_drain: got %h ok=%0d exp %h", d, ok, exp_d); end
    end
  endtask

  task automatic test_ack_at_reset();
    do_reset(1'b1);
    ch_data_i[0 +: DW] = 16'h5A5A;
    ch_valid_i = 4'b0001;
    tick();
    repeat (4) begin
      checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL stale_ack_hold: got %b exp 0", hsk_valid_o); end
      tick();
    end
    hsk_ack_i = 1'b0;
    tick();
    checks++; if (hsk_valid_o !== 1'b1) begin errors++; $display("FAIL stale_ack_release: got %b exp 1", hsk_valid_o); end
    checks++; if (hsk_data_o !== 18'h05A5A) begin errors++; $display("FAIL stale_ack_data: got %h exp 05a5a", hsk_data_o); end
    hsk_ack_i = 1'b1;
    tick();
    hsk_ack_i = 1'b0;
    tick();
    checks++; if (xfer_cnt_o !== 32'd1) begin errors++; $display("FAIL stale_ack_cnt: got %0d exp 1", xfer_cnt_o); end
  endtask

  task automatic test_reset_mid();
    ch_data_i[0 +: DW] = 16'h1111;
    ch_data_i[DW +: DW] = 16'h2222;
    ch_valid_i = 4'b0011;
    tick();
    tick();
    checks++; if (hsk_valid_o !== 1'b1) begin errors++; $display("FAIL mid_send: got %b exp 1", hsk_valid_o); end
    #3;
    rst_ni = 1'b0;
    #1;
    checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", hsk_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", busy_o); end
    checks++; if (xfer_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_cnt: got %0d exp 0", xfer_cnt_o); end
    checks++; if (ch_ready_o !== 4'hF) begin errors++; $display("FAIL mid_ready: got %b exp 1111", ch_ready_o); end
    ch_valid_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      checks++; if (hsk_valid_o !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b exp 0", hsk_valid_o); end
      tick();
    end
  endtask

  task automatic test_cnt_wrap();
    logic [DW+1:0] d;
    bit ok;
    force dut.xfer_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.xfer_cnt_q;
    tick();
    checks++; if (xfer_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h exp ffffffff", xfer_cnt_o); end
    ch_data_i[2*DW +: DW] = 16'h7777;
    ch_valid_i = 4'b0100;
    tick();
    run_xfer(d, ok);
    checks++; if (!ok || d !== 18'h27777) begin errors++; $display("FAIL wrap_data: got %h ok=%0d exp 27777", d, ok); end
    checks++; if (xfer_cnt_o !== 32'd0) begin errors++; $display("FAIL wrap_cnt: got %h exp 0", xfer_cnt_o); end
  endtask

  task automatic test_random();
    int ptr, grants, k;
    bit prev_valid, must, done, any;
    logic [NCH-1:0] exp_rdy;
    logic [DW+1:0] exp_d;
    ptr = 0;
    grants = 0;
    prev_valid = 1'b0;
    must = 1'b0;
    done = 1'b0;
    for (int j = 0; j < NCH; j++) q[j].delete();
    do_reset(1'b0);
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      tick();
      if (must) begin
        checks++; if (hsk_valid_o !== 1'b1) begin errors++; $display("FAIL rand_missed_grant: cycle %0d got %b exp 1", cyc, hsk_valid_o); end
      end
      if (hsk_valid_o && !prev_valid) begin
        k = -1;
        for (int j = 0; j < NCH; j++) if (k < 0 && q[(ptr + j) % NCH].size() > 0) k = (ptr + j) % NCH;
        checks++;
        if (k < 0) begin
          errors++; $display("FAIL rand_spurious_grant: cycle %0d got %h exp no grant", cyc, hsk_data_o);
        end else begin
          exp_d = {2'(k), q[k][0]};
          if (hsk_data_o !== exp_d) begin errors++; $display("FAIL rand_grant: cycle %0d got %h exp %h", cyc, hsk_data_o, exp_d); end
          void'(q[k].pop_front());
          ptr = (k + 1) % NCH;
          grants++;
        end
      end
      for (int j = 0; j < NCH; j++) if (acc[j]) q[j].push_back(acc_data[j*DW +: DW]);
      for (int j = 0; j < NCH; j++) exp_rdy[j] = q[j].size() < DEPTH;
      checks++; if (ch_ready_o !== exp_rdy) begin errors++; $display("FAIL rand_ready: cycle %0d got %b exp %b", cyc, ch_ready_o, exp_rdy); end
      prev_valid = hsk_valid_o;
      any = 1'b0;
      for (int j = 0; j < NCH; j++) if (q[j].size() > 0) any = 1'b1;
      if (cyc < 3000) begin
        for (int j = 0; j < NCH; j++)
          if (!ch_valid_i[j] && $urandom_range(0, 3) == 0) begin
            ch_data_i[j*DW +: DW] = 16'($urandom);
            ch_valid_i[j] = 1'b1;
          end
        if (hsk_valid_o) begin
          if (!hsk_ack_i && $urandom_range(0, 2) == 0) hsk_ack_i = 1'b1;
        end else if (hsk_ack_i) begin
          if ($urandom_range(0, 2) == 0) hsk_ack_i = 1'b0;
        end else if (!busy_o && $urandom_range(0, 15) == 0) hsk_ack_i = 1'b1;
      end else begin
        hsk_ack_i = hsk_valid_o;
        done = ch_valid_i == '0 && !any && !busy_o && !hsk_valid_o;
      end
      must = !busy_o && !hsk_ack_i && any;
    end
    checks++; if (!done) begin errors++; $display("FAIL rand_drain: got busy=%b exp drained", busy_o); end
    checks++; if (xfer_cnt_o !== 32'(grants)) begin errors++; $display("FAIL rand_cnt: got %0d exp %0d", xfer_cnt_o, grants); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_ack_at_reset();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
